ex_operand_stage: RTL and testbench

//   ID/EX pipeline register that drives the ALU's SrcA, SrcB and sel inputs.
//   - Captures decoded operands and selects the operand sources (register, PC, immediate).
//   - Resolves data forwarding from the MEM and WB stages.
//   - Masks shift amounts to RV32I semantics.
//   - Holds its entry under back-pressure using a valid/ready handshake.
//   - Sits between the decode stage and the ALU.

---
 rtl/ex_operand_stage.sv | 157 +++++++++++++++
 tb/tb_ex_operand_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX operand register: captures decoded operands, resolves MEM/WB forwarding,
// and drives the ALU's SrcA/SrcB/sel with RV32I shift-amount masking.
//
// Ports:
//   clk, rst_n      clock / async active-low reset
//   flush           kill the held and incoming entry
//   in_*            decode-side handshake and operands
//   fwd_mem_*       MEM-stage forwarding source (highest priority)
//   fwd_wb_*        WB-stage forwarding source
//   out_valid/ready EX-side handshake
//   SrcA, SrcB, sel ALU operands and op code
//   out_rd_addr     destination index
//   out_reg_write   write enable, 0 whenever out_valid is 0
//   out_store_data  forwarded rs2 value for stores
module ex_operand_stage #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RF_ADDR_W-1:0] in_rs1_addr,
  input  logic [RF_ADDR_W-1:0] in_rs2_addr,
  input  logic [RF_ADDR_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]      in_rs1_data,
  input  logic [XLEN-1:0]      in_rs2_data,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [2:0]           in_alu_sel,
  input  logic                 in_srca_pc,
  input  logic                 in_srcb_imm,
  input  logic                 in_reg_write,
  input  logic                 fwd_mem_en,
  input  logic [RF_ADDR_W-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]      fwd_mem_data,
  input  logic                 fwd_wb_en,
  input  logic [RF_ADDR_W-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]      fwd_wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      SrcA,
  output logic [XLEN-1:0]      SrcB,
  output logic [2:0]           sel,
  output logic [RF_ADDR_W-1:0] out_rd_addr,
  output logic                 out_reg_write,
  output logic [XLEN-1:0]      out_store_data
);

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rs1_addr;
    logic [RF_ADDR_W-1:0] rs2_addr;
    logic [RF_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]      rs1_val;
    logic [XLEN-1:0]      rs2_val;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      pc;
    logic [2:0]           sel;
    logic                 srca_pc;
    logic                 srcb_imm;
    logic                 reg_write;
  } entry_t;

  entry_t ent_q, ent_d;
  logic   valid_q, valid_d;
  logic   capture;
  logic   hold;

  // MEM beats WB beats the supplied value; x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd(
    input logic [RF_ADDR_W-1:0] a,
    input logic [XLEN-1:0]      v,
    input logic                 m_en,
    input logic [RF_ADDR_W-1:0] m_rd,
    input logic [XLEN-1:0]      m_d,
    input logic                 w_en,
    input logic [RF_ADDR_W-1:0] w_rd,
    input logic [XLEN-1:0]      w_d
  );
    logic m_hit, w_hit;
    logic [XLEN-1:0] r;
    m_hit = m_en && (m_rd == a) && (a != '0);
    w_hit = w_en && (w_rd == a) && (a != '0);
    unique case (1'b1)
      m_hit:            r = m_d;
      !m_hit && w_hit:  r = w_d;
      default:          r = v;
    endcase
    return r;
  endfunction

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign hold     = valid_q && !out_ready;

  always_comb begin
    ent_d   = ent_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d         = 1'b0;
      ent_d.reg_write = 1'b0;
    end else if (capture) begin
      valid_d         = 1'b1;
      ent_d.rs1_addr  = in_rs1_addr;
      ent_d.rs2_addr  = in_rs2_addr;
      ent_d.rd_addr   = in_rd_addr;
      ent_d.rs1_val   = fwd(in_rs1_addr, in_rs1_data,
                            fwd_mem_en, fwd_mem_rd, fwd_mem_data,
                            fwd_wb_en, fwd_wb_rd, fwd_wb_data);
      ent_d.rs2_val   = fwd(in_rs2_addr, in_rs2_data,
                            fwd_mem_en, fwd_mem_rd, fwd_mem_data,
                            fwd_wb_en, fwd_wb_rd, fwd_wb_data);
      ent_d.imm       = in_imm;
      ent_d.pc        = in_pc;
      ent_d.sel       = in_alu_sel;
      ent_d.srca_pc   = in_srca_pc;
      ent_d.srcb_imm  = in_srcb_imm;
      ent_d.reg_write = in_reg_write;
    end else if (hold) begin
      // A stalled entry keeps picking up results retiring behind it.
      ent_d.rs1_val = fwd(ent_q.rs1_addr, ent_q.rs1_val,
                          fwd_mem_en, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_en, fwd_wb_rd, fwd_wb_data);
      ent_d.rs2_val = fwd(ent_q.rs2_addr, ent_q.rs2_val,
                          fwd_mem_en, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_en, fwd_wb_rd, fwd_wb_data);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      valid_q <= valid_d;
    end
  end

  logic [XLEN-1:0] opb;
  logic            is_shift;

  assign opb      = ent_q.srcb_imm ? ent_q.imm : ent_q.rs2_val;
  assign is_shift = (ent_q.sel == 3'b001) || (ent_q.sel == 3'b101);

  assign SrcA           = ent_q.srca_pc ? ent_q.pc : ent_q.rs1_val;
  assign SrcB           = is_shift ? {{(XLEN-5){1'b0}}, opb[4:0]} : opb;
  assign sel            = ent_q.sel;
  assign out_valid      = valid_q;
  assign out_rd_addr    = ent_q.rd_addr;
  assign out_reg_write  = valid_q && ent_q.reg_write;
  assign out_store_data = ent_q.rs2_val;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: vector table for capture/forward/mux,
// plus hand-written stall, flush and reset sequences.
module tb_ex_operand_stage;

  logic        clk, rst_n, flush;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic [2:0]  in_alu_sel;
  logic        in_srca_pc, in_srcb_imm, in_reg_write;
  logic        fwd_mem_en, fwd_wb_en;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        out_valid, out_ready;
  logic [31:0] SrcA, SrcB, out_store_data;
  logic [2:0]  sel;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;

  int applied = 0;
  int fails   = 0;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd_addr(in_rd_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc), .in_alu_sel(in_alu_sel),
    .in_srca_pc(in_srca_pc), .in_srcb_imm(in_srcb_imm),
    .in_reg_write(in_reg_write),
    .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd),
    .fwd_mem_data(fwd_mem_data),
    .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd),
    .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .sel(sel),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
    .out_store_data(out_store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic [2:0]  sel;
    logic        apc, bimm, rw;
    logic        men;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        wen;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic [31:0] ea, eb, est;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_rs1_addr  = v.rs1;
    in_rs2_addr  = v.rs2;
    in_rd_addr   = v.rd;
    in_rs1_data  = v.d1;
    in_rs2_data  = v.d2;
    in_imm       = v.imm;
    in_pc        = v.pc;
    in_alu_sel   = v.sel;
    in_srca_pc   = v.apc;
    in_srcb_imm  = v.bimm;
    in_reg_write = v.rw;
    fwd_mem_en   = v.men;
    fwd_mem_rd   = v.mrd;
    fwd_mem_data = v.mdat;
    fwd_wb_en    = v.wen;
    fwd_wb_rd    = v.wrd;
    fwd_wb_data  = v.wdat;
  endtask

  task automatic no_fwd();
    fwd_mem_en = 1'b0;
    fwd_wb_en  = 1'b0;
  endtask

  initial begin
    // rs1 rs2 rd  d1 d2 imm pc  sel apc bimm rw  men mrd mdat  wen wrd wdat  ea eb est
    vt[0] = '{5'd3, 5'd0, 5'd1, 32'd10, 32'd0, 32'd5, 32'h100,
              3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0,
              1'b0, 5'd0, 32'd0, 32'd10, 32'd5, 32'd0};
    vt[1] = '{5'd7, 5'd0, 5'd2, 32'h11, 32'd0, 32'd0, 32'h104,
              3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'hAA,
              1'b1, 5'd7, 32'hBB, 32'hAA, 32'd0, 32'd0};
    vt[2] = '{5'd0, 5'd0, 5'd2, 32'h11, 32'd0, 32'd0, 32'h108,
              3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 32'hAA,
              1'b1, 5'd0, 32'hBB, 32'h11, 32'd0, 32'd0};
    vt[3] = '{5'd1, 5'd2, 5'd3, 32'h80000000, 32'h123, 32'd0, 32'h10C,
              3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0,
              1'b0, 5'd0, 32'd0, 32'h80000000, 32'h3, 32'h123};
    vt[4] = '{5'd1, 5'd0, 5'd3, 32'd7, 32'd0, 32'hFFFFFFE5, 32'h110,
              3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0,
              1'b0, 5'd0, 32'd0, 32'd7, 32'd5, 32'd0};
    vt[5] = '{5'd5, 5'd9, 5'd4, 32'h21, 32'h22, 32'd0, 32'h114,
              3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 32'h88,
              1'b1, 5'd9, 32'h77, 32'h21, 32'h77, 32'h77};
    vt[6] = '{5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'h3000, 32'h1000,
              3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0,
              1'b0, 5'd0, 32'd0, 32'h1000, 32'h3000, 32'd0};
    vt[7] = '{5'd6, 5'd7, 5'd6, 32'h5, 32'h12345678, 32'd0, 32'h118,
              3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,
              1'b0, 5'd0, 32'd0, 32'h5, 32'h12345678, 32'h12345678};
    vt[8] = '{5'd10, 5'd11, 5'd7, 32'h1, 32'h2, 32'd0, 32'h11C,
              3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 5'd11, 32'hCAFE,
              1'b1, 5'd10, 32'hBEEF, 32'hBEEF, 32'hCAFE, 32'hCAFE};
    vt[9] = '{5'd12, 5'd13, 5'd8, 32'h44, 32'h4444, 32'd0, 32'h120,
              3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 5'd12, 32'h99,
              1'b0, 5'd12, 32'h98, 32'h44, 32'h4444, 32'h4444};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(vt[0]);
    no_fwd();
    #12;
    rst_n = 1'b1;
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_srca", SrcA, 32'd0);
    chk("rst_srcb", SrcB, 32'd0);
    chk("rst_rw", {31'd0, out_reg_write}, 32'd0);

    // Back-to-back captures from the vector table.
    for (int i = 0; i < 10; i++) begin
      drive(vt[i]);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_srca", i), SrcA, vt[i].ea);
      chk($sformatf("v%0d_srcb", i), SrcB, vt[i].eb);
      chk($sformatf("v%0d_sel", i), {29'd0, sel}, {29'd0, vt[i].sel});
      chk($sformatf("v%0d_rd", i), {27'd0, out_rd_addr}, {27'd0, vt[i].rd});
      chk($sformatf("v%0d_rw", i), {31'd0, out_reg_write},
          {31'd0, vt[i].rw});
      chk($sformatf("v%0d_st", i), out_store_data, vt[i].est);
    end

    // Drain.
    in_valid = 1'b0;
    no_fwd();
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // Stall refresh: rs2=x4 held as 1, then WB writes x4=0x55.
    in_valid = 1'b1; out_ready = 1'b0;
    in_rs1_addr = 5'd1; in_rs1_data = 32'h2;
    in_rs2_addr = 5'd4; in_rs2_data = 32'h1;
    in_rd_addr = 5'd9; in_alu_sel = 3'b000;
    in_srca_pc = 1'b0; in_srcb_imm = 1'b0; in_reg_write = 1'b1;
    step();
    chk("hold_srcb0", SrcB, 32'h1);
    chk("hold_ready0", {31'd0, in_ready}, 32'd0);
    in_rs2_data = 32'h99; in_alu_sel = 3'b111;
    fwd_wb_en = 1'b1; fwd_wb_rd = 5'd4; fwd_wb_data = 32'h55;
    step();
    chk("hold_srcb1", SrcB, 32'h55);
    chk("hold_st1", out_store_data, 32'h55);
    chk("hold_sel1", {29'd0, sel}, 32'd0);
    chk("hold_ready1", {31'd0, in_ready}, 32'd0);
    chk("hold_valid1", {31'd0, out_valid}, 32'd1);
    fwd_mem_en = 1'b1; fwd_mem_rd = 5'd1; fwd_mem_data = 32'h66;
    fwd_wb_rd = 5'd1; fwd_wb_data = 32'h77;
    step();
    chk("hold_srca2", SrcA, 32'h66);
    chk("hold_srcb2", SrcB, 32'h55);
    no_fwd();

    // Flush a held entry.
    flush = 1'b1;
    step();
    chk("flh_valid", {31'd0, out_valid}, 32'd0);
    chk("flh_rw", {31'd0, out_reg_write}, 32'd0);

    // Flush together with in_valid: nothing captured.
    out_ready = 1'b1; in_valid = 1'b1;
    step();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;
    in_rs1_addr = 5'd3; in_rs1_data = 32'h31;
    in_imm = 32'd9; in_srcb_imm = 1'b1;
    step();
    chk("post_fl_valid", {31'd0, out_valid}, 32'd1);
    chk("post_fl_srca", SrcA, 32'h31);
    chk("post_fl_srcb", SrcB, 32'd9);

    // Reset in the middle of a hold.
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_srca", SrcA, 32'd0);
    chk("mrst_srcb", SrcB, 32'd0);
    chk("mrst_sel", {29'd0, sel}, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("mrst_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_valid2", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
    $finish;
  end

endmodule
